pipe_stage_skid_reg: RTL and testbench

//  Parametrised elastic pipeline stage register for inter-stage boundaries (IF/DEC, DEC/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid_reg_if.sv | 25 ++
 rtl/pipe_stage_skid_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one elastic pipeline stage boundary: upstream (in_*) and downstream (out_*) sides.
// The stage itself takes the slave view, and the neighbouring stages or bench take the master view.
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer, flush, and saturating stall/bubble counters.
// Every output comes straight from a flop, so no combinational path runs from the inputs to the outputs.
//
//  state | meaning
//  EMPTY | no entry held; out_valid=0, in_ready=1
//  ONE   | head holds an entry; skid empty; in_ready=1
//  FULL  | head and skid both hold entries; in_ready=0
module pipe_stage_skid_reg #(
    parameter int               DATA_W   = 32,
    parameter int               CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
    parameter int               CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipe_stage_skid_reg_if.slave   bus,
    input  logic                   flush,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       bubble_count
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt, skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic              out_valid_q, in_ready_q;
    logic              accept, consume;

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            head_data   <= '0;
            head_ctrl   <= NOP_CTRL;
            skid_data   <= '0;
            skid_ctrl   <= NOP_CTRL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_nxt;
            head_data   <= head_data_nxt;
            head_ctrl   <= head_ctrl_nxt;
            skid_data   <= skid_data_nxt;
            skid_ctrl   <= skid_ctrl_nxt;
            out_valid_q <= (state_nxt != EMPTY);
            in_ready_q  <= (state_nxt != FULL);
        end
    end

    // head_ctrl is forced to NOP whenever the head slot empties, so out_ctrl needs no output mux.
    always_comb begin
        state_nxt     = state;
        head_data_nxt = head_data;
        head_ctrl_nxt = head_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (flush) begin
            state_nxt     = EMPTY;
            head_data_nxt = '0;
            head_ctrl_nxt = NOP_CTRL;
            skid_data_nxt = '0;
            skid_ctrl_nxt = NOP_CTRL;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        head_data_nxt = bus.in_data;
                        head_ctrl_nxt = bus.in_ctrl;
                        state_nxt     = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_data_nxt = bus.in_data;
                        head_ctrl_nxt = bus.in_ctrl;
                    end else if (accept) begin
                        skid_data_nxt = bus.in_data;
                        skid_ctrl_nxt = bus.in_ctrl;
                        state_nxt     = FULL;
                    end else if (consume) begin
                        head_ctrl_nxt = NOP_CTRL;
                        state_nxt     = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        head_data_nxt = skid_data;
                        head_ctrl_nxt = skid_ctrl;
                        skid_data_nxt = '0;
                        skid_ctrl_nxt = NOP_CTRL;
                        state_nxt     = ONE;
                    end
                end
                default: begin
                    state_nxt     = EMPTY;
                    head_ctrl_nxt = NOP_CTRL;
                end
            endcase
        end
    end

    // Counters sample the pre-flush handshake and survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (out_valid_q && !bus.out_ready && (stall_count != '1))
                stall_count <= stall_count + CNT_INC;
            if (!out_valid_q && (bubble_count != '1))
                bubble_count <= bubble_count + CNT_INC;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = head_data;
    assign bus.out_ctrl  = head_ctrl;
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed and scoreboard-checked bench for pipe_stage_skid_reg, built with a 4-bit counter width so saturation is reachable.
module tb_pipe_stage_skid_reg;
    localparam int          DATA_W = 32;
    localparam int          CTRL_W = 16;
    localparam int          CNT_W  = 4;
    localparam logic [15:0] NOP    = 16'h00F0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] stall_count, bubble_count;
    int               tests = 0;
    int               fails = 0;

    pipe_stage_skid_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus();

    pipe_stage_skid_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .stall_count(stall_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (!rst_n) !bus.out_valid |-> bus.out_ctrl == NOP)
        else begin
            fails++;
            $display("FAIL assert_nop_ctrl out_ctrl=%h required %h", bus.out_ctrl, NOP);
        end

    function automatic logic [15:0] ctrl_of(input logic [31:0] d);
        return d[15:0] ^ 16'hA5A5;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_ctrl   = ctrl_of(d);
        bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
        flush = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
        tests++; if (bus.out_ctrl !== NOP) begin fails++; $display("FAIL reset_out_ctrl got %h exp %h", bus.out_ctrl, NOP); end
        tests++; if (stall_count !== 4'd0 || bubble_count !== 4'd0) begin fails++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_count, bubble_count); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            step();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i) || bus.out_ctrl !== ctrl_of(32'(i)) || bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_%0d got v=%b d=%h c=%h r=%b exp v=1 d=%h c=%h r=1", i, bus.out_valid, bus.out_data, bus.out_ctrl, bus.in_ready, i, ctrl_of(32'(i)));
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        tests++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== NOP) begin fails++; $display("FAIL stream_drain got v=%b c=%h exp v=0 c=%h", bus.out_valid, bus.out_ctrl, NOP); end
        tests++; if (bus.out_data !== 32'h8) begin fails++; $display("FAIL stream_data_retain got %h exp 8", bus.out_data); end
        tests++; if (stall_count !== 4'd0) begin fails++; $display("FAIL stream_stall got %0d exp 0", stall_count); end
    endtask

    task automatic fill_full();
        drive(1'b1, 32'h11, 1'b0);
        step();
        drive(1'b1, 32'h22, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_full_drain();
        do_reset();
        fill_full();
        tests++; if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h11) begin fails++; $display("FAIL full_state got r=%b d=%h exp r=0 d=11", bus.in_ready, bus.out_data); end
        step();
        tests++; if (stall_count !== 4'd2) begin fails++; $display("FAIL full_stall got %0d exp 2", stall_count); end
        bus.out_ready = 1'b1;
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22 || bus.out_ctrl !== ctrl_of(32'h22) || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL full_drain_b got v=%b d=%h c=%h r=%b exp v=1 d=22 r=1", bus.out_valid, bus.out_data, bus.out_ctrl, bus.in_ready);
        end
        step();
        tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h22) begin fails++; $display("FAIL full_drain_empty got v=%b d=%h exp v=0 d=22", bus.out_valid, bus.out_data); end
        tests++; if (stall_count !== 4'd2) begin fails++; $display("FAIL full_stall_final got %0d exp 2", stall_count); end
    endtask

    task automatic test_flush();
        do_reset();
        fill_full();
        flush = 1'b1;
        drive(1'b1, 32'h33, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        tests++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== NOP || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_state got v=%b c=%h d=%h r=%b exp v=0 c=%h d=0 r=1", bus.out_valid, bus.out_ctrl, bus.out_data, bus.in_ready, NOP);
        end
        tests++; if (stall_count !== 4'd2) begin fails++; $display("FAIL flush_stall got %0d exp 2", stall_count); end
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_emit_%0d got v=%b d=%h exp v=0", i, bus.out_valid, bus.out_data); end
        end
    endtask

    task automatic test_comb_isolation();
        do_reset();
        drive(1'b1, 32'h11, 1'b0);
        step();
        drive(1'b0, 32'hFFFF_FFFF, 1'b1);
        flush = 1'b1;
        #1;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h11 || bus.out_ctrl !== ctrl_of(32'h11) || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL comb_isolation got v=%b d=%h c=%h r=%b exp v=1 d=11 r=1", bus.out_valid, bus.out_data, bus.out_ctrl, bus.in_ready);
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b1, 32'h44, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 4) begin
                tests++; if (stall_count !== 4'd5) begin fails++; $display("FAIL stall_mid got %0d exp 5", stall_count); end
            end
        end
        tests++; if (stall_count !== 4'd15) begin fails++; $display("FAIL stall_sat got %0d exp 15", stall_count); end
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        tests++; if (bubble_count !== 4'd15) begin fails++; $display("FAIL bubble_sat got %0d exp 15", bubble_count); end
        tests++; if (stall_count !== 4'd15) begin fails++; $display("FAIL stall_hold got %0d exp 15", stall_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_full();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 32'h0 || bus.out_ctrl !== NOP) begin
            fails++; $display("FAIL async_reset got v=%b r=%b d=%h c=%h exp v=0 r=1 d=0 c=%h", bus.out_valid, bus.in_ready, bus.out_data, bus.out_ctrl, NOP);
        end
        tests++; if (stall_count !== 4'd0 || bubble_count !== 4'd0) begin fails++; $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", stall_count, bubble_count); end
        step();
        rst_n = 1'b1;
        drive(1'b1, 32'h55, 1'b1);
        step();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55 || bus.out_ctrl !== ctrl_of(32'h55)) begin
            fails++; $display("FAIL post_reset_55 got v=%b d=%h c=%h exp v=1 d=55", bus.out_valid, bus.out_data, bus.out_ctrl);
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_drain got v=%b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] seq;
        logic        iv, ordy, fl, acc, con;
        do_reset();
        seq = 32'h100;
        for (int n = 0; n < 10000; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            drive(iv, seq, ordy);
            flush = fl;
            tests++;
            if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < 2) ||
                (q.size() != 0 && (bus.out_data !== q[0] || bus.out_ctrl !== ctrl_of(q[0]))) ||
                (q.size() == 0 && bus.out_ctrl !== NOP)) begin
                fails++;
                $display("FAIL random_%0d got v=%b r=%b d=%h c=%h exp v=%b r=%b d=%h", n, bus.out_valid, bus.in_ready,
                         bus.out_data, bus.out_ctrl, q.size() != 0, q.size() < 2, (q.size() != 0) ? q[0] : 32'h0);
            end
            acc = iv && (q.size() < 2);
            con = (q.size() != 0) && ordy;
            step();
            if (fl) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(seq);
            end
            if (acc) seq = seq + 32'h1;
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);
        test_reset();
        test_stream();
        test_full_drain();
        test_flush();
        test_comb_isolation();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
